// File: rtl/bist_runner.sv
// bist_runner: reader/executor side of the TAP BIST vector memory.
// Steps through the loaded config/check pairs on RUNBIST, drives each config
// nibble to the DUT, waits a settle window, compares the response and publishes
// {done, error, first_fail, fail_cnt} on BIST_DATA.
// Optional: define BIST_SIGNATURE_EN to add the BIST_SIG 8-bit response MISR.
module bist_runner #(
  parameter int DEPTH  = 6,
  parameter int SETTLE = 2,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              TCK,
  input  logic              TRST_N,
  input  logic              TLR,
  input  logic              RUNBIST_SELECT,
  input  logic              RTI,
  input  logic [3:0]        VEC_COUNT,
  output logic [ADDR_W-1:0] VEC_ADDR,
  input  logic [3:0]        VEC_CONFIG,
  input  logic [3:0]        VEC_CHECK,
  output logic [3:0]        BIST_OUT,
  input  logic [3:0]        BIST_IN,
  output logic              RESET_SM,
`ifdef BIST_SIGNATURE_EN
  output logic [7:0]        BIST_SIG,
`endif
  output logic [7:0]        BIST_DATA
);

  localparam int CNT_W = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    IDLE, START, FETCH, SETTLE_W, CHECK, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [3:0]          n_q, n_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          exp_q, exp_d;
  logic [3:0]          bist_out_q, bist_out_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [2:0]          ff_q, ff_d;
  logic [2:0]          fcnt_q, fcnt_d;
  logic [3:0]          n_clip;
  logic                running;

`ifdef BIST_SIGNATURE_EN
  logic [7:0]          sig_q, sig_d;

  // One MISR shift: x^8+x^4+x^3+x^2+1 feedback, response folded into the low nibble.
  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [3:0] d);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {4'h0, d};
  endfunction

  assign BIST_SIG = sig_q;
`endif

  assign n_clip    = (VEC_COUNT > 4'(DEPTH)) ? 4'(DEPTH) : VEC_COUNT;
  assign running   = (state_q == START) || (state_q == FETCH) ||
                     (state_q == SETTLE_W) || (state_q == CHECK);
  assign VEC_ADDR  = idx_q;
  assign BIST_OUT  = bist_out_q;
  assign RESET_SM  = (state_q == START);
  assign BIST_DATA = {done_q, err_q, ff_q, fcnt_q};

  // Next-state and datapath update; abort on RUNBIST_SELECT loss overrides the step.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    bist_out_d = bist_out_q;
    done_d     = done_q;
    err_d      = err_q;
    ff_d       = ff_q;
    fcnt_d     = fcnt_q;
`ifdef BIST_SIGNATURE_EN
    sig_d      = sig_q;
`endif
    case (state_q)
      IDLE: begin
        if (RUNBIST_SELECT && RTI) begin
          // Results are cleared on entry so BIST_DATA already reads 0 in START.
          state_d = START;
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          ff_d    = 3'd0;
          fcnt_d  = 3'd0;
`ifdef BIST_SIGNATURE_EN
          sig_d   = 8'h00;
`endif
        end
      end
      START: begin
        n_d = n_clip;
        if (n_clip == 4'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        bist_out_d = VEC_CONFIG;
        exp_d      = VEC_CHECK;
        cnt_d      = CNT_W'(SETTLE - 1);
        state_d    = SETTLE_W;
      end
      SETTLE_W: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CHECK: begin
        if (BIST_IN != exp_q) begin
          err_d = 1'b1;
          if (fcnt_q != 3'd7) fcnt_d = fcnt_q + 3'd1;
          if (!err_q)         ff_d   = 3'(idx_q);
        end
`ifdef BIST_SIGNATURE_EN
        sig_d = misr_step(sig_q, BIST_IN);
`endif
        if (4'(idx_q) == n_q - 4'd1) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end
      DONE: begin
        if (!RUNBIST_SELECT) begin
          state_d    = IDLE;
          bist_out_d = 4'h0;
          idx_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (running && !RUNBIST_SELECT) begin
      state_d    = IDLE;
      bist_out_d = 4'h0;
      idx_d      = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      ff_d       = 3'd0;
      fcnt_d     = 3'd0;
`ifdef BIST_SIGNATURE_EN
      sig_d      = 8'h00;
`endif
    end
  end

  // State and result registers; TRST_N and TLR clear identically.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      n_q        <= 4'd0;
      cnt_q      <= '0;
      exp_q      <= 4'h0;
      bist_out_q <= 4'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ff_q       <= 3'd0;
      fcnt_q     <= 3'd0;
`ifdef BIST_SIGNATURE_EN
      sig_q      <= 8'h00;
`endif
    end else if (TLR) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      n_q        <= 4'd0;
      cnt_q      <= '0;
      exp_q      <= 4'h0;
      bist_out_q <= 4'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ff_q       <= 3'd0;
      fcnt_q     <= 3'd0;
`ifdef BIST_SIGNATURE_EN
      sig_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      bist_out_q <= bist_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ff_q       <= ff_d;
      fcnt_q     <= fcnt_d;
`ifdef BIST_SIGNATURE_EN
      sig_q      <= sig_d;
`endif
    end
  end

endmodule

// File: tb/tb_bist_runner.sv
// Directed bench for bist_runner with a vector memory model, a DUT response
// model and a scoreboard of expected BIST_DATA words.
module tb_bist_runner;

  localparam int DEPTH  = 6;
  localparam int SETTLE = 2;
  localparam int AW     = 3;

  logic          TCK = 1'b0;
  logic          TRST_N, TLR, RUNBIST_SELECT, RTI;
  logic [3:0]    VEC_COUNT, VEC_CONFIG, VEC_CHECK, BIST_OUT, BIST_IN;
  logic [AW-1:0] VEC_ADDR;
  logic          RESET_SM;
  logic [7:0]    BIST_DATA;
`ifdef BIST_SIGNATURE_EN
  logic [7:0]    BIST_SIG;
`endif

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0: echo model, 1: response held at 0, 2: 0xF on vector 0 only

  logic [3:0] cfg  [8] = '{4'h3, 4'h5, 4'h9, 4'hC, 4'hA, 4'h6, 4'h1, 4'h2};
  logic [3:0] flip [8];
  logic [7:0] sb [$];

  bist_runner #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .TCK(TCK), .TRST_N(TRST_N), .TLR(TLR), .RUNBIST_SELECT(RUNBIST_SELECT),
    .RTI(RTI), .VEC_COUNT(VEC_COUNT), .VEC_ADDR(VEC_ADDR),
    .VEC_CONFIG(VEC_CONFIG), .VEC_CHECK(VEC_CHECK), .BIST_OUT(BIST_OUT),
    .BIST_IN(BIST_IN), .RESET_SM(RESET_SM),
`ifdef BIST_SIGNATURE_EN
    .BIST_SIG(BIST_SIG),
`endif
    .BIST_DATA(BIST_DATA)
  );

  always #5 TCK = ~TCK;

  assign VEC_CONFIG = cfg[VEC_ADDR];
  assign VEC_CHECK  = ~cfg[VEC_ADDR];

  always_comb begin
    BIST_IN = 4'h0;
    case (mode)
      0:       BIST_IN = ~BIST_OUT ^ flip[VEC_ADDR];
      2:       BIST_IN = (VEC_ADDR == 3'd0) ? 4'hF : 4'h0;
      default: BIST_IN = 4'h0;
    endcase
  end

  function automatic logic [3:0] resp(input int k);
    case (mode)
      0:       return ~cfg[k] ^ flip[k];
      2:       return (k == 0) ? 4'hF : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [7:0] model(input int m);
    logic       e = 1'b0;
    logic [2:0] f = 3'd0;
    int         cnt = 0;
    for (int k = 0; k < m; k++) begin
      if (resp(k) != ~cfg[k]) begin
        if (!e) f = 3'(k);
        e = 1'b1;
        if (cnt < 7) cnt++;
      end
    end
    return {1'b1, e, f, 3'(cnt)};
  endfunction

  function automatic logic [7:0] sig_model(input int m);
    logic [7:0] s = 8'h00;
    for (int k = 0; k < m; k++)
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {4'h0, resp(k)};
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run; abort_c >= 0 drops RUNBIST_SELECT at that cycle after START.
  task automatic run(input logic [3:0] vc, input int abort_c);
    int         c, pulses, maxa, m;
    logic [7:0] e;
    bit         started;
    m = (int'(vc) > DEPTH) ? DEPTH : int'(vc);
    if (abort_c < 0) sb.push_back(model(m));
    VEC_COUNT = vc;
    RUNBIST_SELECT = 1'b1;
    RTI = 1'b1;
    started = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge TCK);
      if (RESET_SM) begin started = 1'b1; break; end
    end
    check("start_seen", 32'(started), 1);
    if (!started) begin
      if (abort_c < 0) e = sb.pop_front();
      RUNBIST_SELECT = 1'b0;
      return;
    end
    RTI = 1'b0;
    check("start_data_clear", BIST_DATA, 0);
    pulses = 1;
    maxa = int'(VEC_ADDR);
    c = 0;
    while (!BIST_DATA[7] && c < 200) begin
      @(negedge TCK);
      c++;
      if (RESET_SM) pulses++;
      if (int'(VEC_ADDR) > maxa) maxa = int'(VEC_ADDR);
      if (c == 1 && m > 0) check("first_addr", VEC_ADDR, 0);
      if (c == abort_c) begin
        check("abort_at_vec3", VEC_ADDR, 3);
        RUNBIST_SELECT = 1'b0;
        @(negedge TCK);
        check("abort_out", BIST_OUT, 0);
        check("abort_data", BIST_DATA, 0);
        check("abort_addr", VEC_ADDR, 0);
        check("abort_reset_sm", RESET_SM, 0);
        return;
      end
    end
    check("done_cycle", c, m * (SETTLE + 2) + 1);
    check("reset_pulses", pulses, 1);
    check("max_addr", maxa, (m == 0) ? 0 : m - 1);
    e = sb.pop_front();
    check("bist_data", BIST_DATA, e);
    if (m > 0) check("hold_cfg", BIST_OUT, cfg[m-1]);
    repeat (3) @(negedge TCK);
    check("done_hold", BIST_DATA, e);
    RUNBIST_SELECT = 1'b0;
    @(negedge TCK);
    check("idle_out", BIST_OUT, 0);
    check("idle_keep", BIST_DATA, e);
    check("idle_addr", VEC_ADDR, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) flip[k] = 4'h0;
    TRST_N = 1'b0; TLR = 1'b0; RUNBIST_SELECT = 1'b0; RTI = 1'b0; VEC_COUNT = 4'd0;
    #12;
    @(negedge TCK);
    check("rst_out", BIST_OUT, 0);
    check("rst_data", BIST_DATA, 0);
    check("rst_addr", VEC_ADDR, 0);
    check("rst_reset_sm", RESET_SM, 0);
    TRST_N = 1'b1;
    @(negedge TCK);
    check("rel_out", BIST_OUT, 0);

    // All vectors pass.
    run(4'd6, -1);
    // Vectors 2 and 4 mismatch.
    flip[2] = 4'h1; flip[4] = 4'h8;
    run(4'd6, -1);
    // Empty run, then an over-range count clipped to DEPTH.
    run(4'd0, -1);
    flip[2] = 4'h0; flip[4] = 4'h0; flip[5] = 4'h2;
    run(4'd9, -1);
    // Abort in vector 3 settle window, then a clean re-entry.
    flip[5] = 4'h0; flip[1] = 4'h4;
    run(4'd6, 14);
    run(4'd6, -1);

    // TLR mid-run.
    VEC_COUNT = 4'd6; RUNBIST_SELECT = 1'b1; RTI = 1'b1;
    repeat (11) @(negedge TCK);
    check("pre_tlr_out", BIST_OUT, cfg[2]);
    TLR = 1'b1;
    @(negedge TCK);
    check("tlr_out", BIST_OUT, 0);
    check("tlr_data", BIST_DATA, 0);
    check("tlr_addr", VEC_ADDR, 0);
    check("tlr_reset_sm", RESET_SM, 0);
    TLR = 1'b0; RUNBIST_SELECT = 1'b0; RTI = 1'b0;
    @(negedge TCK);
    check("post_tlr_out", BIST_OUT, 0);
    check("post_tlr_data", BIST_DATA, 0);

`ifdef BIST_SIGNATURE_EN
    flip[1] = 4'h0;
    mode = 1;
    run(4'd6, -1);
    check("sig_zero", BIST_SIG, 0);
    mode = 2;
    run(4'd6, -1);
    check("sig_f_vec0", BIST_SIG, sig_model(6));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
